button_input_pio: RTL and testbench

Parametrised N-channel push-button input peripheral for the game processor system, generalising the single-bit pause, reset and jump button exports. Each channel is synchronised, debounced and edge-captured. Firmware sees the state through an Avalon-MM slave with a level register, an interrupt-mask register and a write-1-to-clear edge-capture register. A level-sensitive interrupt is raised for any unmasked captured press.

---
 rtl/button_input_pio.sv | 133 +++++++++++++
 tb/tb_button_input_pio.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/button_input_pio.sv
// rtl/button_input_pio.sv - N-channel debounced push-button input peripheral with Avalon-MM registers and level irq
// Optional build macro: BUTTON_PIO_BOTH_EDGES_EN (EDGE also captures debounced releases; ID bit 8 = 1)
module button_input_pio #(
  parameter int N_CHANNELS      = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [N_CHANNELS-1:0] buttons_export,
  input  logic [1:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Synchroniser reset value is the idle pin level so no press appears out of reset
  localparam logic [N_CHANNELS-1:0] RELEASED_PIN = {N_CHANNELS{ACTIVE_LOW}};

`ifdef BUTTON_PIO_BOTH_EDGES_EN
  localparam logic BOTH_EDGES = 1'b1;
`else
  localparam logic BOTH_EDGES = 1'b0;
`endif

  localparam logic [31:0] ID_VALUE = {16'h0B7E, 7'd0, BOTH_EDGES, 8'(N_CHANNELS)};

  logic [N_CHANNELS-1:0] sync1_q, sync1_d;
  logic [N_CHANNELS-1:0] sync2_q, sync2_d;
  logic [N_CHANNELS-1:0] state_q, state_d;
  logic [CW-1:0]         cnt_q [N_CHANNELS];
  logic [CW-1:0]         cnt_d [N_CHANNELS];
  logic [N_CHANNELS-1:0] mask_q, mask_d;
  logic [N_CHANNELS-1:0] edge_q, edge_d;
  logic [31:0]           readdata_q, readdata_d;

  logic [N_CHANNELS-1:0] pressed;
  logic [N_CHANNELS-1:0] toggle;
  logic [N_CHANNELS-1:0] edge_set;
  logic [N_CHANNELS-1:0] edge_clr;
  logic                  unused_wdata;

  // Bits of writedata above the channel count are deliberately ignored
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser and polarity normalisation to pressed = 1
  always_comb begin
    sync1_d = buttons_export;
    sync2_d = sync1_q;
    pressed = sync2_q ^ {N_CHANNELS{ACTIVE_LOW}};
  end

  // Per-channel debounce: count while the synchronised level disagrees, toggle on the last count
  always_comb begin
    state_d = state_q;
    toggle  = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          toggle[i]  = 1'b1;
          state_d[i] = ~state_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Edge capture and register writes; a new edge wins over a simultaneous W1C
  always_comb begin
`ifdef BUTTON_PIO_BOTH_EDGES_EN
    edge_set = toggle;
`else
    edge_set = toggle & ~state_q;
`endif
    edge_clr = '0;
    mask_d   = mask_q;
    if (write && address == 2'd1) begin
      mask_d = writedata[N_CHANNELS-1:0];
    end
    if (write && address == 2'd2) begin
      edge_clr = writedata[N_CHANNELS-1:0];
    end
    edge_d = (edge_q & ~edge_clr) | edge_set;
  end

  // Registered read mux; holds its value when no read is strobed
  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        2'd0:    readdata_d = 32'(state_q);
        2'd1:    readdata_d = 32'(mask_q);
        2'd2:    readdata_d = 32'(edge_q);
        default: readdata_d = ID_VALUE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q    <= RELEASED_PIN;
      sync2_q    <= RELEASED_PIN;
      state_q    <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < N_CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_button_input_pio.sv
// tb/tb_button_input_pio.sv - self-checking bench for button_input_pio (N=3, debounce 4, active-low pins)
module tb_button_input_pio;

`ifdef BUTTON_PIO_BOTH_EDGES_EN
  localparam logic        BOTH   = 1'b1;
  localparam logic [31:0] ID_EXP = 32'h0B7E_0103;
`else
  localparam logic        BOTH   = 1'b0;
  localparam logic [31:0] ID_EXP = 32'h0B7E_0003;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pins;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  pins;
    int          hold;
    logic [1:0]  addr;
    logic [31:0] exp;
    logic        exp_irq;
    logic        rd;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  logic rd_seen = 1'b0;

  button_input_pio #(
    .N_CHANNELS(3),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .buttons_export(pins),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_seen <= read;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_read", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, readdata, e.val);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    read    = 1'b1;
    exp_q.push_back('{exp, name});
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    address   = a;
    writedata = d;
    write     = 1'b1;
    read      = 1'b1;
    exp_q.push_back('{exp, name});
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    pins = 3'b111; address = 2'd0; read = 1'b0; write = 1'b0; writedata = 32'd0; rst_n = 1'b0;

    vecs.push_back('{3'b111, 2,  2'd3, ID_EXP, 1'b0, 1'b1, "id"});
    vecs.push_back('{3'b111, 0,  2'd0, 32'd0,  1'b0, 1'b1, "data_rst"});
    vecs.push_back('{3'b111, 0,  2'd2, 32'd0,  1'b0, 1'b1, "edge_rst"});
    vecs.push_back('{3'b111, 0,  2'd1, 32'd0,  1'b0, 1'b1, "mask_rst"});
    vecs.push_back('{3'b110, 3,  2'd0, 32'd0,  1'b0, 1'b0, "glitch_lo"});
    vecs.push_back('{3'b111, 10, 2'd0, 32'd0,  1'b0, 1'b1, "glitch_data"});
    vecs.push_back('{3'b111, 0,  2'd2, 32'd0,  1'b0, 1'b1, "glitch_edge"});

    cycles(3);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      pins = vecs[k].pins;
      cycles(vecs[k].hold);
      check({vecs[k].name, "_irq"}, 32'(irq), 32'(vecs[k].exp_irq));
      if (vecs[k].rd) do_read(vecs[k].addr, vecs[k].exp, vecs[k].name);
    end

    // clean press on pin1: DATA changes exactly 6 cycles after the pin
    pins = 3'b101;
    cycles(5);
    do_read(2'd0, 32'd0, "press_early");
    do_read(2'd0, 32'd2, "press_data");
    check("press_irq_masked", 32'(irq), 32'd0);
    do_read(2'd2, 32'd2, "press_edge");
    do_write(2'd1, 32'd2);
    check("press_irq_unmasked", 32'(irq), 32'd1);

    // W1C of one edge keeps irq, clearing the last drops it next cycle
    pins = 3'b100;
    cycles(8);
    do_write(2'd1, 32'd7);
    do_read(2'd2, 32'd3, "w1c_setup");
    do_write(2'd2, 32'd1);
    check("w1c_irq_hold", 32'(irq), 32'd1);
    do_read(2'd2, 32'd2, "w1c_first");
    do_write(2'd2, 32'd2);
    check("w1c_irq_drop", 32'(irq), 32'd0);
    do_read(2'd2, 32'd0, "w1c_second");

    // read during write of the same register returns the old value; upper bits ignored
    do_rw(2'd1, 32'd0, 32'd7, "rw_pre");
    do_read(2'd1, 32'd0, "rw_post");
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read(2'd1, 32'd7, "mask_upper");

    // W1C of bit2 on the same edge pin2's press completes: set wins
    pins = 3'b000;
    cycles(5);
    do_write(2'd2, 32'd4);
    do_read(2'd2, 32'd4, "coll_set");
    check("coll_irq", 32'(irq), 32'd1);
    do_write(2'd2, 32'd4);
    do_read(2'd2, 32'd0, "coll_clear");
    check("coll_irq_clear", 32'(irq), 32'd0);

    // release of pin0: captured only in the both-edges build
    pins = 3'b001;
    cycles(5);
    do_read(2'd2, 32'd0, "rel_early");
    do_read(2'd2, 32'(BOTH), "rel_edge");
    check("rel_irq", 32'(irq), 32'(BOTH));
    do_read(2'd0, 32'd6, "rel_data");
    do_write(2'd2, 32'd7);

    // reset in the middle of a debounce restarts counting from zero
    pins = 3'b111;
    cycles(8);
    pins = 3'b110;
    cycles(3);
    rst_n = 1'b0;
    cycles(2);
    check("rst2_readdata", readdata, 32'd0);
    check("rst2_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    cycles(5);
    do_read(2'd0, 32'd0, "rst2_early");
    do_read(2'd0, 32'd1, "rst2_data");
    do_read(2'd2, 32'd1, "rst2_edge");

    cycles(2);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
